p_simd_mac_unit: RTL and testbench

// - Parametrised, pipelined packed-SIMD multiply / multiply-accumulate unit for the RV32I P-extension execute path.
// - Splits XLEN-bit operands into XLEN/ELEM_W lanes and returns a packed result after STAGES cycles.
// - Uses a valid/ready handshake, so the pipeline can stall it on hazards and flush it on redirect.
// - Successor to the fixed single-cycle datapath: lane width and depth are configurable, with backpressure and an optional saturation mode.

---
 rtl/p_simd_mac_unit.sv | 186 ++++++++++++++++++
 tb/tb_p_simd_mac_unit.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_simd_mac_unit.sv
// Pipelined packed-SIMD multiply / multiply-accumulate unit with valid/ready flow control.
// Optional lane saturation and sticky overflow flag are enabled by defining PSIMD_SAT_EN.
module p_simd_mac_unit #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ELEM_W = 8,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic             is_signed,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   input  logic [XLEN-1:0]  acc,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             ov_sticky,
   input  logic             ov_clr
);

   localparam int unsigned LANES = XLEN / ELEM_W;
   // Two guard bits above the full product keep acc +/- p exact in every sign mode.
   localparam int unsigned PW    = 2 * ELEM_W + 2;

   typedef enum logic [1:0] {
      OpMul  = 2'b00,
      OpMulh = 2'b01,
      OpMac  = 2'b10,
      OpMsu  = 2'b11
   } op_e;

`ifdef PSIMD_SAT_EN
   localparam logic signed [PW-1:0] SMAX = PW'((2 ** (ELEM_W - 1)) - 1);
   localparam logic signed [PW-1:0] SMIN = ~SMAX;
   localparam logic signed [PW-1:0] UMAX = PW'((2 ** ELEM_W) - 1);
`endif

   logic [XLEN-1:0]  lane_res;
   logic [LANES-1:0] lane_ov;

   // ---------------------------------------------------------------------------
   // Per-lane arithmetic (combinational, ahead of the first pipeline register)
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [ELEM_W-1:0]    a;
      logic [ELEM_W-1:0]    b;
      logic [ELEM_W-1:0]    c;
      logic signed [PW-1:0] a_x;
      logic signed [PW-1:0] b_x;
      logic signed [PW-1:0] c_x;
      logic signed [PW-1:0] p_x;
      logic signed [PW-1:0] exact;
      logic [ELEM_W-1:0]    lane_val;
      logic                 lane_sat;

      assign a = rs1[g*ELEM_W +: ELEM_W];
      assign b = rs2[g*ELEM_W +: ELEM_W];
      assign c = acc[g*ELEM_W +: ELEM_W];

      assign a_x = {{(PW - ELEM_W){is_signed & a[ELEM_W-1]}}, a};
      assign b_x = {{(PW - ELEM_W){is_signed & b[ELEM_W-1]}}, b};
      assign c_x = {{(PW - ELEM_W){is_signed & c[ELEM_W-1]}}, c};

      assign p_x = a_x * b_x;

      always_comb begin
         exact = p_x;
         if (op == OpMac) begin
            exact = c_x + p_x;
         end else if (op == OpMsu) begin
            exact = c_x - p_x;
         end
      end

`ifdef PSIMD_SAT_EN
      logic signed [PW-1:0] hi;
      logic signed [PW-1:0] lo;

      assign hi = is_signed ? SMAX : UMAX;
      assign lo = is_signed ? SMIN : '0;

      always_comb begin
         lane_val = exact[ELEM_W-1:0];
         lane_sat = 1'b0;
         if (op == OpMulh) begin
            lane_val = p_x[2*ELEM_W-1:ELEM_W];
         end else if (exact > hi) begin
            lane_val = hi[ELEM_W-1:0];
            lane_sat = 1'b1;
         end else if (exact < lo) begin
            lane_val = lo[ELEM_W-1:0];
            lane_sat = 1'b1;
         end
      end
`else
      logic unused_upper;

      assign lane_val = (op == OpMulh) ? p_x[2*ELEM_W-1:ELEM_W] : exact[ELEM_W-1:0];
      assign lane_sat = 1'b0;
      assign unused_upper = ^{exact[PW-1:ELEM_W], p_x[PW-1:2*ELEM_W]};
`endif

      assign lane_res[g*ELEM_W +: ELEM_W] = lane_val;
      assign lane_ov[g]                   = lane_sat;
   end

   // ---------------------------------------------------------------------------
   // Pipeline: all stages move together on advance; flush only kills valids
   // ---------------------------------------------------------------------------
   logic             advance;
   logic             v_q   [STAGES];
   logic [XLEN-1:0]  res_q [STAGES];
   logic [TAG_W-1:0] tag_q [STAGES];
   logic             ovf_q [STAGES];

   assign advance = ~v_q[STAGES-1] | out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            v_q[i]   <= 1'b0;
            res_q[i] <= '0;
            tag_q[i] <= '0;
            ovf_q[i] <= 1'b0;
         end
      end else begin
         if (advance) begin
            for (int i = 1; i < STAGES; i++) begin
               v_q[i]   <= v_q[i-1];
               res_q[i] <= res_q[i-1];
               tag_q[i] <= tag_q[i-1];
               ovf_q[i] <= ovf_q[i-1];
            end
            v_q[0] <= in_valid;
            if (in_valid) begin
               res_q[0] <= lane_res;
               tag_q[0] <= in_tag;
               ovf_q[0] <= |lane_ov;
            end
         end
         // Later assignment overrides the shift: a flush empties every stage.
         if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
               v_q[i] <= 1'b0;
            end
         end
      end
   end

   assign in_ready   = advance;
   assign out_valid  = v_q[STAGES-1];
   assign out_result = res_q[STAGES-1];
   assign out_tag    = tag_q[STAGES-1];

   // ---------------------------------------------------------------------------
   // Sticky saturation flag, updated only on an output handshake
   // ---------------------------------------------------------------------------
`ifdef PSIMD_SAT_EN
   logic ov_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q <= 1'b0;
      end else if (out_valid && out_ready && ovf_q[STAGES-1]) begin
         ov_q <= 1'b1;
      end else if (ov_clr) begin
         ov_q <= 1'b0;
      end
   end

   assign ov_sticky = ov_q;
`else
   logic unused_ov;

   assign unused_ov = ^{ov_clr, ovf_q[STAGES-1]};
   assign ov_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_p_simd_mac_unit.sv
// Self-checking bench for p_simd_mac_unit (ELEM_W=8, STAGES=2): directed vector table,
// multi-cycle corner sequences, and randomized traffic against a lane-arithmetic model.
module tb_p_simd_mac_unit;

   localparam int XLEN  = 32;
   localparam int W     = 8;
   localparam int LANES = XLEN / W;
   localparam int TAG_W = 5;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic             is_signed;
   logic [XLEN-1:0]  rs1;
   logic [XLEN-1:0]  rs2;
   logic [XLEN-1:0]  acc;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;
   logic             ov_sticky;
   logic             ov_clr;

   int checks;
   int failures;

   p_simd_mac_unit #(
      .XLEN   (XLEN),
      .ELEM_W (W),
      .STAGES (2),
      .TAG_W  (TAG_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .is_signed  (is_signed),
      .rs1        (rs1),
      .rs2        (rs2),
      .acc        (acc),
      .in_tag     (in_tag),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .ov_sticky  (ov_sticky),
      .ov_clr     (ov_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  op;
      logic        sgn;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] acc;
      logic [31:0] exp_wrap;
      logic [31:0] exp_sat;
      logic        exp_ov;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v, input logic [TAG_W-1:0] t);
      op        = v.op;
      is_signed = v.sgn;
      rs1       = v.rs1;
      rs2       = v.rs2;
      acc       = v.acc;
      in_tag    = t;
   endtask

   function automatic logic [31:0] exp_res(input vec_t v);
`ifdef PSIMD_SAT_EN
      return v.exp_sat;
`else
      return v.exp_wrap;
`endif
   endfunction

   function automatic logic exp_ovf(input vec_t v);
`ifdef PSIMD_SAT_EN
      return v.exp_ov;
`else
      return 1'b0;
`endif
   endfunction

   // Lane-by-lane integer arithmetic straight from the operation definitions.
   function automatic logic [31:0] ref_mac(input logic [1:0] f_op, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, output logic ov);
      logic [31:0] r;
      logic [7:0]  ea, eb, ec;
      int x, y, z, p, v, hi, lo;
      r  = '0;
      ov = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         ea = a[l*W +: W];
         eb = b[l*W +: W];
         ec = c[l*W +: W];
         if (sgn) begin
            x = int'($signed(ea));
            y = int'($signed(eb));
            z = int'($signed(ec));
         end else begin
            x = int'(ea);
            y = int'(eb);
            z = int'(ec);
         end
         p = x * y;
         case (f_op)
            2'd0:    v = p;
            2'd1:    v = p >>> W;
            2'd2:    v = z + p;
            default: v = z - p;
         endcase
         hi = sgn ? (1 << (W - 1)) - 1 : (1 << W) - 1;
         lo = sgn ? -(1 << (W - 1)) : 0;
`ifdef PSIMD_SAT_EN
         if (f_op != 2'd1) begin
            if (v > hi) begin
               v  = hi;
               ov = 1'b1;
            end else if (v < lo) begin
               v  = lo;
               ov = 1'b1;
            end
         end
`else
         if (hi < lo) ov = 1'b1;
`endif
         r[l*W +: W] = v[7:0];
      end
      return r;
   endfunction

   task automatic pulse_clr();
      ov_clr = 1'b1;
      step();
      ov_clr = 1'b0;
   endtask

   // Issue one request into an idle unit and wait (bounded) for its result.
   task automatic run_one(input vec_t v, input logic [TAG_W-1:0] t, output logic [31:0] res,
                          output logic [TAG_W-1:0] otag, output int lat);
      drive(v, t);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      res  = out_result;
      otag = out_tag;
      step();
   endtask

   logic [31:0]      res;
   logic [TAG_W-1:0] otag;
   int               lat;

   initial begin
      vec_t bp;
      int   accepts;
      int   next_tag;
      int   seen;
      int   got [$];
      logic [31:0]      q_res [$];
      logic [TAG_W-1:0] q_tag [$];
      logic             q_ov  [$];
      logic             model_ov;
      logic             pop_ov;
      logic             new_ov;
      logic             acc_hs;
      logic             out_hs;
      int               issued;

      checks   = 0;
      failures = 0;

      //          op     sgn   rs1           rs2           acc           wrap          sat           ov
      vecs[0] = '{2'd0, 1'b1, 32'h0203FF80, 32'h0305FF02, 32'h00000000, 32'h060F0100, 32'h060F0180, 1'b1};
      vecs[1] = '{2'd2, 1'b0, 32'h01020304, 32'h02020202, 32'h10101010, 32'h12141618, 32'h12141618, 1'b0};
      vecs[2] = '{2'd1, 1'b1, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h00000000, 32'h3F3F3F3F, 32'h3F3F3F3F, 1'b0};
      vecs[3] = '{2'd3, 1'b0, 32'h01020304, 32'h02020202, 32'h00100510, 32'hFE0CFF08, 32'h000C0008, 1'b1};
      vecs[4] = '{2'd0, 1'b0, 32'hFF100203, 32'h02108004, 32'h00000000, 32'hFE00000C, 32'hFFFFFF0C, 1'b1};
      vecs[5] = '{2'd1, 1'b0, 32'hFFFF8001, 32'hFF02FF80, 32'h00000000, 32'hFE017F00, 32'hFE017F00, 1'b0};
      vecs[6] = '{2'd2, 1'b1, 32'h01011002, 32'h01FF1003, 32'h7F8000F0, 32'h807F00F6, 32'h7F807FF6, 1'b1};
      vecs[7] = '{2'd3, 1'b1, 32'h02FF0000, 32'h03FF0000, 32'h05050505, 32'hFF040505, 32'hFF040505, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 2'd0;
      is_signed = 1'b0;
      rs1       = '0;
      rs2       = '0;
      acc       = '0;
      in_tag    = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      ov_clr    = 1'b0;

      #3;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_result", out_result, 32'd0);
      check("reset_out_tag", 32'(out_tag), 32'd0);
      check("reset_ov_sticky", 32'(ov_sticky), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors, one at a time.
      for (int i = 0; i < 8; i++) begin
         pulse_clr();
         run_one(vecs[i], TAG_W'(i), res, otag, lat);
         check($sformatf("vec%0d_result", i), res, exp_res(vecs[i]));
         check($sformatf("vec%0d_tag", i), 32'(otag), 32'(i));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         check($sformatf("vec%0d_ov_sticky", i), 32'(ov_sticky), 32'(exp_ovf(vecs[i])));
      end

      // Set wins over a simultaneous clear; a lone clear then empties the flag.
      pulse_clr();
      drive(vecs[0], 5'd4);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("setclr_out_valid", 32'(out_valid), 32'd1);
      ov_clr = 1'b1;
      step();
      ov_clr = 1'b0;
      check("setclr_set_wins", 32'(ov_sticky), 32'(exp_ovf(vecs[0])));
      pulse_clr();
      check("setclr_cleared", 32'(ov_sticky), 32'd0);

      // Backpressure: consumer stalls for 6 cycles while tags 0..3 are offered.
      bp       = vecs[0];
      bp.op    = 2'd0;
      bp.sgn   = 1'b0;
      bp.rs2   = 32'h01010101;
      out_ready = 1'b0;
      accepts  = 0;
      next_tag = 0;
      for (int c = 0; c < 6; c++) begin
         bp.rs1   = {4{8'(next_tag + 1)}};
         drive(bp, TAG_W'(next_tag));
         in_valid = (next_tag < 4);
         #1;
         acc_hs = in_valid & in_ready;
         step();
         if (acc_hs) begin
            accepts++;
            next_tag++;
         end
      end
      in_valid = 1'b0;
      #1;
      check("bp_accepts", 32'(accepts), 32'd2);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_tag_held", 32'(out_tag), 32'd0);
      check("bp_out_result_held", out_result, 32'h01010101);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && got.size() < 4; c++) begin
         bp.rs1   = {4{8'(next_tag + 1)}};
         drive(bp, TAG_W'(next_tag));
         in_valid = (next_tag < 4);
         #1;
         acc_hs = in_valid & in_ready;
         if (out_valid) begin
            check($sformatf("bp_result_tag%0d", out_tag), out_result, {4{8'(out_tag + 1)}});
            got.push_back(int'(out_tag));
         end
         step();
         if (acc_hs) next_tag++;
      end
      in_valid = 1'b0;
      check("bp_count", 32'(got.size()), 32'd4);
      for (int i = 0; i < got.size(); i++) begin
         check($sformatf("bp_order%0d", i), 32'(got[i]), 32'(i));
      end

      // Flush one cycle after issuing tag 7; the request in the flush cycle is dropped too.
      pulse_clr();
      drive(vecs[0], 5'd7);
      in_valid = 1'b1;
      step();
      flush = 1'b1;
      drive(vecs[4], 5'd9);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      seen     = 0;
      for (int c = 0; c < 3; c++) begin
         if (out_valid) seen++;
         step();
      end
      check("flush_no_output", 32'(seen), 32'd0);
      check("flush_no_sticky", 32'(ov_sticky), 32'd0);
      run_one(vecs[1], 5'd8, res, otag, lat);
      check("flush_next_tag", 32'(otag), 32'd8);
      check("flush_next_latency", 32'(lat), 32'd2);
      check("flush_next_result", res, 32'h12141618);

      // Asynchronous reset with two requests in flight.
      pulse_clr();
      drive(vecs[0], 5'd1);
      in_valid = 1'b1;
      step();
      drive(vecs[0], 5'd2);
      step();
      in_valid = 1'b0;
      #1;
      check("rst_pre_out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_ov_sticky", 32'(ov_sticky), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (out_valid) seen++;
      end
      check("rst_no_replay", 32'(seen), 32'd0);
      bp     = vecs[0];
      bp.op  = 2'd0;
      bp.sgn = 1'b0;
      bp.rs1 = 32'h01010101;
      bp.rs2 = 32'h02020202;
      run_one(bp, 5'd3, res, otag, lat);
      check("rst_post_result", res, 32'h02020202);
      check("rst_post_latency", 32'(lat), 32'd2);

      // Randomized traffic with random backpressure against the lane model.
      pulse_clr();
      model_ov = 1'b0;
      issued   = 0;
      for (int c = 0; c < 3000; c++) begin
         op        = 2'($urandom_range(0, 3));
         is_signed = 1'($urandom_range(0, 1));
         rs1       = $urandom;
         rs2       = ($urandom_range(0, 3) == 0) ? 32'h7F80FF01 : $urandom;
         acc       = $urandom;
         in_tag    = TAG_W'(issued);
         in_valid  = (issued < 600) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         ov_clr    = ($urandom_range(0, 15) == 0);
         #1;
         acc_hs = in_valid & in_ready;
         out_hs = out_valid & out_ready;
         pop_ov = 1'b0;
         if (out_hs) begin
            if (q_res.size() == 0) begin
               check("rand_unexpected_output", 32'(out_tag), 32'hFFFFFFFF);
            end else begin
               check("rand_result", out_result, q_res.pop_front());
               check("rand_tag", 32'(out_tag), 32'(q_tag.pop_front()));
               pop_ov = q_ov.pop_front();
            end
         end
         if (acc_hs) begin
            q_res.push_back(ref_mac(op, is_signed, rs1, rs2, acc, new_ov));
            q_tag.push_back(in_tag);
            q_ov.push_back(new_ov);
            issued++;
         end
         if (pop_ov) model_ov = 1'b1;
         else if (ov_clr) model_ov = 1'b0;
         step();
         check("rand_ov_sticky", 32'(ov_sticky), 32'(model_ov));
      end
      in_valid  = 1'b0;
      ov_clr    = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10 && q_res.size() > 0; c++) begin
         #1;
         if (out_valid) begin
            check("drain_result", out_result, q_res.pop_front());
            check("drain_tag", 32'(out_tag), 32'(q_tag.pop_front()));
            void'(q_ov.pop_front());
         end
         step();
      end
      check("rand_all_returned", 32'(q_res.size()), 32'd0);
      check("rand_issued_some", 32'(issued > 100), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
